// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory-controller port between the I-cache refill and
// D-cache interfaces; I-line refills stay contiguous via a line lock, otherwise round-robin.
module mem_port_arbiter #(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        IMemRead,
    input  logic [31:0] IMemReadAddr,
    output logic        IDataValid,
    output logic [31:0] IDataIn,
    input  logic        DMemRead,
    input  logic        DMemWrite,
    input  logic [31:0] DMemAddr,
    input  logic [31:0] DMemWriteData,
    output logic        DDataValid,
    output logic [31:0] DDataIn,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWriteData,
    input  logic        MemDataValid,
    input  logic [31:0] MemDataIn
);
    localparam int unsigned CNT_W = $clog2(LINE_WORDS) + 1;

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
    typedef enum logic {OWNER_I, OWNER_D} owner_t;

    state_t           state_q, state_d;
    owner_t           last_owner_q, last_owner_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [31:4]      lock_line_q, lock_line_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    logic d_req;
    logic lock_hit;
    logic grant_i;
    logic grant_d;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_D;
            lock_cnt_q   <= '0;
            lock_line_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_line_q  <= lock_line_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        lock_cnt_d   = lock_cnt_q;
        lock_line_d  = lock_line_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        d_req    = DMemRead | DMemWrite;
        lock_hit = (lock_cnt_q != '0) && IMemRead && (IMemReadAddr[31:4] == lock_line_q);
        grant_i  = lock_hit || (IMemRead && (!d_req || (last_owner_q == OWNER_D)));
        grant_d  = d_req && !grant_i;

        case (state_q)
            IDLE: begin
                if (!lock_hit) begin
                    lock_cnt_d = '0;
                end
                if (grant_i) begin
                    state_d      = I_BUSY;
                    last_owner_d = OWNER_I;
                    mem_read_d   = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = IMemReadAddr;
                    mem_wdata_d  = '0;
                end else if (grant_d) begin
                    // A simultaneous read+write request is issued as a write.
                    state_d      = D_BUSY;
                    last_owner_d = OWNER_D;
                    mem_read_d   = DMemRead & ~DMemWrite;
                    mem_write_d  = DMemWrite;
                    mem_addr_d   = DMemAddr;
                    mem_wdata_d  = DMemWriteData;
                end
            end
            I_BUSY, D_BUSY: begin
                if (MemDataValid) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if (state_q == I_BUSY) begin
                        if (lock_cnt_q == '0) begin
                            lock_cnt_d  = CNT_W'(LINE_WORDS - 1);
                            lock_line_d = mem_addr_q[31:4];
                        end else begin
                            lock_cnt_d = lock_cnt_q - CNT_W'(1);
                        end
                    end else begin
                        lock_cnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        IDataValid = 1'b0;
        IDataIn    = '0;
        DDataValid = 1'b0;
        DDataIn    = '0;
        if (MemDataValid) begin
            if (state_q == I_BUSY) begin
                IDataValid = 1'b1;
                IDataIn    = MemDataIn;
            end else if (state_q == D_BUSY) begin
                DDataValid = 1'b1;
                DDataIn    = MemDataIn;
            end
        end
    end

    assign MemRead      = mem_read_q;
    assign MemWrite     = mem_write_q;
    assign MemAddr      = mem_addr_q;
    assign MemWriteData = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int unsigned LW = 4;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        IMemRead;
    logic [31:0] IMemReadAddr;
    logic        IDataValid;
    logic [31:0] IDataIn;
    logic        DMemRead;
    logic        DMemWrite;
    logic [31:0] DMemAddr;
    logic [31:0] DMemWriteData;
    logic        DDataValid;
    logic [31:0] DDataIn;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [31:0] MemWriteData;
    logic        MemDataValid;
    logic [31:0] MemDataIn;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [65:0] mem_obs;
    logic [65:0] ack_obs;
    assign mem_obs = {MemRead, MemWrite, MemAddr, MemWriteData};
    assign ack_obs = {IDataValid, IDataIn, DDataValid, DDataIn};

    mem_port_arbiter #(.LINE_WORDS(LW)) dut (
        .CLK(CLK), .Reset(Reset),
        .IMemRead(IMemRead), .IMemReadAddr(IMemReadAddr),
        .IDataValid(IDataValid), .IDataIn(IDataIn),
        .DMemRead(DMemRead), .DMemWrite(DMemWrite), .DMemAddr(DMemAddr),
        .DMemWriteData(DMemWriteData), .DDataValid(DDataValid), .DDataIn(DDataIn),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddr(MemAddr),
        .MemWriteData(MemWriteData), .MemDataValid(MemDataValid), .MemDataIn(MemDataIn)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [65:0] mb(logic r, logic w, logic [31:0] a, logic [31:0] d);
        return {r, w, a, d};
    endfunction

    function automatic logic [65:0] ab(logic iv, logic [31:0] id, logic dv, logic [31:0] dd);
        return {iv, id, dv, dd};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        IMemRead = 1'b0; IMemReadAddr = '0;
        DMemRead = 1'b0; DMemWrite = 1'b0; DMemAddr = '0; DMemWriteData = '0;
        MemDataValid = 1'b0; MemDataIn = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [65:0] e;
        idle_inputs();
        Reset = 1'b1;
        IMemRead = 1'b1; IMemReadAddr = 32'h40; DMemRead = 1'b1;
        MemDataValid = 1'b1; MemDataIn = 32'hFFFF_FFFF;
        tick();
        tick();
        e = '0;
        total++; if (mem_obs !== e) begin bad++; $display("FAIL reset_mem: got %h want %h", mem_obs, e); end
        total++; if (ack_obs !== e) begin bad++; $display("FAIL reset_ack: got %h want %h", ack_obs, e); end
        idle_inputs();
        Reset = 1'b0;
    endtask

    task automatic test_single_i();
        logic [65:0] e;
        do_reset();
        IMemRead = 1'b1; IMemReadAddr = 32'h0000_1040;
        e = mb(1'b1, 1'b0, 32'h1040, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (mem_obs !== e) begin bad++; $display("FAIL single_grant: cycle %0d got %h want %h", i, mem_obs, e); end
            total++; if (ack_obs !== '0) begin bad++; $display("FAIL single_early_ack: cycle %0d got %h want 0", i, ack_obs); end
        end
        tick();
        MemDataValid = 1'b1; MemDataIn = 32'hDEAD_BEEF;
        #1;
        total++; if (mem_obs !== e) begin bad++; $display("FAIL single_hold: got %h want %h", mem_obs, e); end
        e = ab(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        total++; if (ack_obs !== e) begin bad++; $display("FAIL single_ack: got %h want %h", ack_obs, e); end
        tick();
        MemDataValid = 1'b0; IMemRead = 1'b0;
        #1;
        total++; if (mem_obs !== '0) begin bad++; $display("FAIL single_release: got %h want 0", mem_obs); end
        total++; if (ack_obs !== '0) begin bad++; $display("FAIL single_no_ack: got %h want 0", ack_obs); end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        logic [65:0] e;
        do_reset();
        IMemRead = 1'b1; IMemReadAddr = 32'h100;
        DMemRead = 1'b1; DMemAddr = 32'h8000;
        tick();
        e = mb(1'b1, 1'b0, 32'h100, 32'h0);
        total++; if (mem_obs !== e) begin bad++; $display("FAIL sim_first_i: got %h want %h", mem_obs, e); end
        MemDataValid = 1'b1; MemDataIn = 32'h1111_1111;
        #1;
        e = ab(1'b1, 32'h1111_1111, 1'b0, 32'h0);
        total++; if (ack_obs !== e) begin bad++; $display("FAIL sim_i_ack: got %h want %h", ack_obs, e); end
        tick();
        MemDataValid = 1'b0; IMemReadAddr = 32'h500;
        total++; if (mem_obs !== '0) begin bad++; $display("FAIL sim_dead1: got %h want 0", mem_obs); end
        tick();
        e = mb(1'b1, 1'b0, 32'h8000, 32'h0);
        total++; if (mem_obs !== e) begin bad++; $display("FAIL sim_then_d: got %h want %h", mem_obs, e); end
        MemDataValid = 1'b1; MemDataIn = 32'h2222_2222;
        #1;
        e = ab(1'b0, 32'h0, 1'b1, 32'h2222_2222);
        total++; if (ack_obs !== e) begin bad++; $display("FAIL sim_d_ack: got %h want %h", ack_obs, e); end
        tick();
        MemDataValid = 1'b0; DMemAddr = 32'h8004;
        total++; if (mem_obs !== '0) begin bad++; $display("FAIL sim_dead2: got %h want 0", mem_obs); end
        tick();
        e = mb(1'b1, 1'b0, 32'h500, 32'h0);
        total++; if (mem_obs !== e) begin bad++; $display("FAIL sim_alt_i: got %h want %h", mem_obs, e); end
        MemDataValid = 1'b1; MemDataIn = 32'h3333_3333;
        tick();
        MemDataValid = 1'b0; IMemRead = 1'b0;
        tick();
        e = mb(1'b1, 1'b0, 32'h8004, 32'h0);
        total++; if (mem_obs !== e) begin bad++; $display("FAIL sim_alt_d: got %h want %h", mem_obs, e); end
        MemDataValid = 1'b1; MemDataIn = 32'h4444_4444;
        tick();
        idle_inputs();
    endtask

    task automatic test_line_lock();
        logic [65:0] e;
        logic [31:0] a;
        do_reset();
        DMemWrite = 1'b1; DMemAddr = 32'h9000; DMemWriteData = 32'hA5A5_0001;
        IMemRead = 1'b1; IMemReadAddr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            a = 32'(32'h200 + 4 * k);
            tick();
            e = mb(1'b1, 1'b0, a, 32'h0);
            total++; if (mem_obs !== e) begin bad++; $display("FAIL lock_word%0d: got %h want %h", k, mem_obs, e); end
            tick();
            MemDataValid = 1'b1; MemDataIn = 32'(32'hC0DE_0000 + k);
            #1;
            e = ab(1'b1, 32'(32'hC0DE_0000 + k), 1'b0, 32'h0);
            total++; if (ack_obs !== e) begin bad++; $display("FAIL lock_ack%0d: got %h want %h", k, ack_obs, e); end
            tick();
            MemDataValid = 1'b0;
            total++; if (mem_obs !== '0) begin bad++; $display("FAIL lock_dead%0d: got %h want 0", k, mem_obs); end
            if (k < 3) IMemReadAddr = a + 32'd4;
            else IMemRead = 1'b0;
        end
        tick();
        e = mb(1'b0, 1'b1, 32'h9000, 32'hA5A5_0001);
        total++; if (mem_obs !== e) begin bad++; $display("FAIL lock_d_fifth: got %h want %h", mem_obs, e); end
        MemDataValid = 1'b1; MemDataIn = 32'h5A5A_0000;
        #1;
        e = ab(1'b0, 32'h0, 1'b1, 32'h5A5A_0000);
        total++; if (ack_obs !== e) begin bad++; $display("FAIL lock_d_ack: got %h want %h", ack_obs, e); end
        tick();
        idle_inputs();
    endtask

    task automatic test_lock_break();
        logic [65:0] e;
        do_reset();
        IMemRead = 1'b1; IMemReadAddr = 32'h300;
        DMemRead = 1'b1; DMemAddr = 32'hA000;
        tick();
        e = mb(1'b1, 1'b0, 32'h300, 32'h0);
        total++; if (mem_obs !== e) begin bad++; $display("FAIL break_first_i: got %h want %h", mem_obs, e); end
        MemDataValid = 1'b1; MemDataIn = 32'h0300_0300;
        tick();
        MemDataValid = 1'b0; IMemRead = 1'b0;
        tick();
        e = mb(1'b1, 1'b0, 32'hA000, 32'h0);
        total++; if (mem_obs !== e) begin bad++; $display("FAIL break_d_in_gap: got %h want %h", mem_obs, e); end
        MemDataValid = 1'b1; MemDataIn = 32'h0A00_0A00;
        #1;
        e = ab(1'b0, 32'h0, 1'b1, 32'h0A00_0A00);
        total++; if (ack_obs !== e) begin bad++; $display("FAIL break_d_ack: got %h want %h", ack_obs, e); end
        tick();
        MemDataValid = 1'b0; DMemRead = 1'b0;
        IMemRead = 1'b1; IMemReadAddr = 32'h304;
        tick();
        e = mb(1'b1, 1'b0, 32'h304, 32'h0);
        total++; if (mem_obs !== e) begin bad++; $display("FAIL break_i_resume: got %h want %h", mem_obs, e); end
        MemDataValid = 1'b1;
        tick();
        idle_inputs();
        // An empty IDLE cycle drops the lock, so the next tie goes to D (LastOwner=I).
        do_reset();
        IMemRead = 1'b1; IMemReadAddr = 32'h300;
        tick();
        MemDataValid = 1'b1;
        tick();
        MemDataValid = 1'b0; IMemRead = 1'b0;
        tick();
        IMemRead = 1'b1; IMemReadAddr = 32'h304;
        DMemRead = 1'b1; DMemAddr = 32'hA000;
        tick();
        e = mb(1'b1, 1'b0, 32'hA000, 32'h0);
        total++; if (mem_obs !== e) begin bad++; $display("FAIL clear_then_rr: got %h want %h", mem_obs, e); end
        MemDataValid = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_rw_both();
        logic [65:0] e;
        do_reset();
        DMemRead = 1'b1; DMemWrite = 1'b1; DMemAddr = 32'hB000; DMemWriteData = 32'h1234_5678;
        tick();
        e = mb(1'b0, 1'b1, 32'hB000, 32'h1234_5678);
        total++; if (mem_obs !== e) begin bad++; $display("FAIL rw_both_write: got %h want %h", mem_obs, e); end
        MemDataValid = 1'b1; MemDataIn = 32'h0000_FEED;
        #1;
        e = ab(1'b0, 32'h0, 1'b1, 32'h0000_FEED);
        total++; if (ack_obs !== e) begin bad++; $display("FAIL rw_both_ack: got %h want %h", ack_obs, e); end
        tick();
        idle_inputs();
        total++; if (mem_obs !== '0) begin bad++; $display("FAIL rw_both_release: got %h want 0", mem_obs); end
    endtask

    task automatic test_reset_mid();
        logic [65:0] e;
        do_reset();
        IMemRead = 1'b1; IMemReadAddr = 32'h1040;
        tick();
        e = mb(1'b1, 1'b0, 32'h1040, 32'h0);
        total++; if (mem_obs !== e) begin bad++; $display("FAIL rst_mid_busy: got %h want %h", mem_obs, e); end
        Reset = 1'b1; MemDataValid = 1'b1; MemDataIn = 32'h7777_7777;
        #1;
        total++; if (mem_obs !== '0) begin bad++; $display("FAIL rst_mid_mem: got %h want 0", mem_obs); end
        total++; if (ack_obs !== '0) begin bad++; $display("FAIL rst_mid_ack: got %h want 0", ack_obs); end
        tick();
        Reset = 1'b0; IMemRead = 1'b0; MemDataValid = 1'b1;
        #1;
        total++; if (ack_obs !== '0) begin bad++; $display("FAIL rst_mid_stale_ack: got %h want 0", ack_obs); end
        tick();
        MemDataValid = 1'b0;
        total++; if (mem_obs !== '0) begin bad++; $display("FAIL rst_mid_idle: got %h want 0", mem_obs); end
        DMemRead = 1'b1; DMemAddr = 32'hC000;
        tick();
        e = mb(1'b1, 1'b0, 32'hC000, 32'h0);
        total++; if (mem_obs !== e) begin bad++; $display("FAIL rst_mid_regrant: got %h want %h", mem_obs, e); end
        MemDataValid = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_random(int unsigned cycles);
        int unsigned owner     = 0;   // 0 none, 1 I, 2 D
        int unsigned last      = 2;
        int unsigned lock_left = 0;   // words of the locked line still reserved for I
        logic [27:0] lock_line = '0;
        logic [31:0] cur_addr  = '0;
        logic [65:0] exp_m     = '0;
        logic [65:0] exp_a;
        bit          i_on = 0, d_on = 0, i_acked = 0, d_acked = 0, hit;
        int unsigned mem_wait = 0, d_mode = 0;
        logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
        do_reset();
        for (int unsigned c = 0; c < cycles; c++) begin
            tick();
            total++; if (mem_obs !== exp_m) begin bad++; $display("FAIL rand_mem: cyc %0d got %h want %h", c, mem_obs, exp_m); end
            if (i_acked) begin
                i_on = ($urandom_range(0, 9) < 7);
                i_addr = i_addr + 32'd4;
            end else if (!i_on && $urandom_range(0, 9) < 3) begin
                i_on = 1;
                i_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (d_acked) d_on = 0;
            if (!d_on && $urandom_range(0, 9) < 3) begin
                d_on = 1;
                d_mode = $urandom_range(0, 2);
                d_addr = {$urandom_range(0, 65535) , 2'b00} & 32'h0003_FFFC;
                d_wdata = $urandom;
            end
            IMemRead = i_on;
            IMemReadAddr = i_on ? i_addr : $urandom;
            DMemRead = d_on && (d_mode != 1);
            DMemWrite = d_on && (d_mode != 0);
            DMemAddr = d_addr;
            DMemWriteData = d_wdata;
            if (owner != 0) begin
                MemDataValid = (mem_wait == 0);
                if (mem_wait != 0) mem_wait--;
            end else begin
                MemDataValid = ($urandom_range(0, 9) == 0);
            end
            MemDataIn = $urandom;
            #1;
            exp_a = ab(owner == 1 && MemDataValid, (owner == 1 && MemDataValid) ? MemDataIn : 32'h0,
                       owner == 2 && MemDataValid, (owner == 2 && MemDataValid) ? MemDataIn : 32'h0);
            total++; if (ack_obs !== exp_a) begin bad++; $display("FAIL rand_ack: cyc %0d got %h want %h", c, ack_obs, exp_a); end
            i_acked = (owner == 1) && MemDataValid;
            d_acked = (owner == 2) && MemDataValid;
            if (owner == 0) begin
                hit = (lock_left != 0) && i_on && (i_addr[31:4] == lock_line);
                if (!hit) lock_left = 0;
                if (i_on && (hit || !d_on || last == 2)) begin
                    owner = 1; last = 1; cur_addr = i_addr;
                    exp_m = mb(1'b1, 1'b0, i_addr, 32'h0);
                    mem_wait = $urandom_range(0, 3);
                end else if (d_on) begin
                    owner = 2; last = 2; cur_addr = d_addr;
                    exp_m = mb(d_mode == 0, d_mode != 0, d_addr, d_wdata);
                    mem_wait = $urandom_range(0, 3);
                end
            end else if (MemDataValid) begin
                if (owner == 1) begin
                    if (lock_left == 0) begin
                        lock_left = LW - 1;
                        lock_line = cur_addr[31:4];
                    end else begin
                        lock_left--;
                    end
                end else begin
                    lock_left = 0;
                end
                owner = 0;
                exp_m = '0;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_i();
        test_simultaneous();
        test_line_lock();
        test_lock_break();
        test_rw_both();
        test_reset_mid();
        test_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
